// File: rtl/button_hex_counter.sv
// Debounced Up/Down/Clear pushbuttons driving an 8-bit hex counter with hold-to-repeat.
// The count is presented as two nibbles, one per seven-segment digit encoder.
module button_hex_counter #(
    parameter int DEBOUNCE_CYCLES     = 250000,
    parameter int REPEAT_DELAY_CYCLES = 12500000,
    parameter int REPEAT_RATE_CYCLES  = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Up_Button,
    input  logic       i_Down_Button,
    input  logic       i_Clear_Button,
    output logic [3:0] o_Upper_Nibble,
    output logic [3:0] o_Lower_Nibble,
    output logic       o_Step
);

    localparam int NUM_BTN   = 3;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_CLEAR = 2;

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int RC_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RC_W   = $clog2(RC_MAX);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] DELAY_LAST = RC_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RC_W-1:0] RATE_LAST  = RC_W'(REPEAT_RATE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_t;

    logic [NUM_BTN-1:0] raw_buttons;
    logic [NUM_BTN-1:0] stable;

    assign raw_buttons = {i_Clear_Button, i_Down_Button, i_Up_Button};

    // Two-flop synchronizer followed by a consecutive-difference debounce counter per button
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_debounce
            logic            sync1_reg;
            logic            sync2_reg;
            logic            stable_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge i_Clk) begin
                if (!i_Rst_L) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    stable_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    sync1_reg <= raw_buttons[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        stable_reg <= sync2_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign stable[gi] = stable_reg;
        end
    endgenerate

    dir_t dir_next;
    dir_t dir_reg;

    always_comb begin
        dir_next = DIR_NONE;
        if (stable[BTN_UP] && !stable[BTN_DOWN]) begin
            dir_next = DIR_UP;
        end else if (!stable[BTN_UP] && stable[BTN_DOWN]) begin
            dir_next = DIR_DOWN;
        end
    end

    // Direction is registered so a fresh press lands DEBOUNCE_CYCLES+3 edges after first sample
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            dir_reg <= DIR_NONE;
        end else begin
            dir_reg <= dir_next;
        end
    end

    state_t          state_reg;
    state_t          state_next;
    dir_t            latched_reg;
    dir_t            latched_next;
    logic [RC_W-1:0] rc_reg;
    logic [RC_W-1:0] rc_next;
    logic            step_req;
    logic            step_up;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_reg   <= ST_IDLE;
            latched_reg <= DIR_NONE;
            rc_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            latched_reg <= latched_next;
            rc_reg      <= rc_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        latched_next = latched_reg;
        rc_next      = rc_reg;
        step_req     = 1'b0;
        step_up      = (latched_reg == DIR_UP);
        case (state_reg)
            ST_IDLE: begin
                step_up = (dir_reg == DIR_UP);
                if (dir_reg != DIR_NONE) begin
                    step_req     = 1'b1;
                    latched_next = dir_reg;
                    rc_next      = '0;
                    state_next   = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (dir_reg != latched_reg) begin
                    state_next = ST_IDLE;
                end else if (rc_reg == DELAY_LAST) begin
                    step_req   = 1'b1;
                    rc_next    = '0;
                    state_next = ST_REPEAT;
                end else begin
                    rc_next = rc_reg + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (dir_reg != latched_reg) begin
                    state_next = ST_IDLE;
                end else if (rc_reg == RATE_LAST) begin
                    step_req = 1'b1;
                    rc_next  = '0;
                end else begin
                    rc_next = rc_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    logic       clear_prev_reg;
    logic       clear_rise;
    logic [7:0] count_reg;
    logic       step_reg;

    assign clear_rise = stable[BTN_CLEAR] && !clear_prev_reg;

    // Clear wins over a coincident step; the FSM keeps running so repeats resume from 00
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            clear_prev_reg <= 1'b0;
            count_reg      <= 8'h00;
            step_reg       <= 1'b0;
        end else begin
            clear_prev_reg <= stable[BTN_CLEAR];
            if (clear_rise) begin
                count_reg <= 8'h00;
                step_reg  <= 1'b0;
            end else if (step_req) begin
                count_reg <= step_up ? count_reg + 8'd1 : count_reg - 8'd1;
                step_reg  <= 1'b1;
            end else begin
                step_reg <= 1'b0;
            end
        end
    end

    assign o_Upper_Nibble = count_reg[7:4];
    assign o_Lower_Nibble = count_reg[3:0];
    assign o_Step         = step_reg;

endmodule

// File: tb/tb_button_hex_counter.sv
// Directed bench for button_hex_counter with short debounce and repeat timings.
// Loop index k is the edge number counted from the first edge that samples the new inputs.
module tb_button_hex_counter;

    logic       i_Clk;
    logic       i_Rst_L;
    logic       i_Up_Button;
    logic       i_Down_Button;
    logic       i_Clear_Button;
    logic [3:0] o_Upper_Nibble;
    logic [3:0] o_Lower_Nibble;
    logic       o_Step;

    int n_checks = 0;
    int n_fail   = 0;

    button_hex_counter #(
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (10),
        .REPEAT_RATE_CYCLES  (3)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Rst_L        (i_Rst_L),
        .i_Up_Button    (i_Up_Button),
        .i_Down_Button  (i_Down_Button),
        .i_Clear_Button (i_Clear_Button),
        .o_Upper_Nibble (o_Upper_Nibble),
        .o_Lower_Nibble (o_Lower_Nibble),
        .o_Step         (o_Step)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    function automatic logic [31:0] count_now();
        return 32'({o_Upper_Nibble, o_Lower_Nibble});
    endfunction

    task automatic do_reset();
        i_Rst_L        = 1'b0;
        i_Up_Button    = 1'b0;
        i_Down_Button  = 1'b0;
        i_Clear_Button = 1'b0;
        tick();
        tick();
        i_Rst_L = 1'b1;
    endtask

    // Runs len edges with Up high for the first up_len edges and Down for the first dn_len
    task automatic run(input int len, input int up_len, input int dn_len,
                       output int nsteps, output int last_k);
        nsteps = 0;
        last_k = -1;
        for (int k = 0; k < len; k++) begin
            i_Up_Button   = (k < up_len);
            i_Down_Button = (k < dn_len);
            tick();
            if (o_Step === 1'b1) begin
                nsteps++;
                last_k = k;
            end
        end
        i_Up_Button   = 1'b0;
        i_Down_Button = 1'b0;
    endtask

    initial begin
        int  ns;
        int  lk;
        bit  exp_step;

        // Reset state
        do_reset();
        check("reset_count", count_now(), 32'h00);
        check("reset_step", 32'(o_Step), 32'h0);

        // 1: six-cycle press gives one step at edge 7
        run(30, 6, 0, ns, lk);
        check("t1_nsteps", 32'(ns), 32'd1);
        check("t1_step_edge", 32'(lk), 32'd7);
        check("t1_upper", 32'(o_Upper_Nibble), 32'h0);
        check("t1_lower", 32'(o_Lower_Nibble), 32'h1);

        // 2: hold 40 edges; steps at 7, 17, then every 3 until release takes effect (last at 44)
        do_reset();
        ns = 0;
        for (int k = 0; k < 60; k++) begin
            i_Up_Button = (k < 40);
            tick();
            exp_step = (k == 7) || (k >= 17 && k <= 45 && ((k - 17) % 3) == 0);
            check($sformatf("t2_step_k%0d", k), 32'(o_Step), 32'(exp_step));
            if (o_Step === 1'b1) ns++;
        end
        i_Up_Button = 1'b0;
        check("t2_nsteps", 32'(ns), 32'd11);
        check("t2_count", count_now(), 32'h0B);
        check("t2_count_eq_steps", count_now(), 32'(ns));

        // 3: nibble carry 0F->10, and both wrap directions
        do_reset();
        run(70, 52, 0, ns, lk);
        check("t3_count_0f", count_now(), 32'h0F);
        run(26, 6, 0, ns, lk);
        check("t3_upper_after_carry", 32'(o_Upper_Nibble), 32'h1);
        check("t3_lower_after_carry", 32'(o_Lower_Nibble), 32'h0);
        do_reset();
        run(26, 0, 6, ns, lk);
        check("t3_down_wrap", count_now(), 32'hFF);
        check("t3_down_nsteps", 32'(ns), 32'd1);
        run(26, 6, 0, ns, lk);
        check("t3_up_wrap", count_now(), 32'h00);

        // 4: glitches of 1, 2 and 3 cycles never debounce
        do_reset();
        ns = 0;
        for (int k = 0; k < 30; k++) begin
            i_Up_Button = (k == 0) || (k >= 6 && k < 8) || (k >= 13 && k < 16);
            tick();
            if (o_Step === 1'b1) ns++;
        end
        i_Up_Button = 1'b0;
        check("t4_glitch_nsteps", 32'(ns), 32'd0);
        check("t4_glitch_count", count_now(), 32'h00);
        run(40, 30, 30, ns, lk);
        check("t4_both_nsteps", 32'(ns), 32'd0);
        check("t4_both_count", count_now(), 32'h00);

        // 5: Clear stable rise lands on the repeat step at edge 23
        do_reset();
        for (int k = 0; k < 31; k++) begin
            i_Up_Button    = 1'b1;
            i_Clear_Button = (k >= 17 && k < 25);
            tick();
            exp_step = (k == 7) || (k == 17) || (k == 20) || (k == 26) || (k == 29);
            check($sformatf("t5_step_k%0d", k), 32'(o_Step), 32'(exp_step));
            if (k == 22) check("t5_count_before", count_now(), 32'h03);
            if (k == 23) check("t5_count_cleared", count_now(), 32'h00);
            if (k == 26) check("t5_count_after", count_now(), 32'h01);
        end
        i_Up_Button    = 1'b0;
        i_Clear_Button = 1'b0;

        // 6: one-cycle reset while repeating; fresh press restarts from the reset edge
        do_reset();
        for (int k = 0; k < 46; k++) begin
            i_Up_Button = 1'b1;
            i_Rst_L     = (k != 21);
            tick();
            exp_step = (k == 7) || (k == 17) || (k == 20) || (k == 29) ||
                       (k >= 39 && ((k - 39) % 3) == 0);
            check($sformatf("t6_step_k%0d", k), 32'(o_Step), 32'(exp_step));
            if (k == 20) check("t6_count_pre_reset", count_now(), 32'h03);
            if (k == 21) check("t6_count_reset", count_now(), 32'h00);
            if (k == 29) check("t6_count_first", count_now(), 32'h01);
            if (k == 45) check("t6_count_end", count_now(), 32'h04);
        end
        i_Rst_L     = 1'b1;
        i_Up_Button = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_hex_counter.md
Name: button_hex_counter

Overview:
- Upstream feeder for the two-digit seven-segment path on the Go Board.
- Debounces Up, Down and Clear pushbuttons and runs a hold-to-repeat state machine.
- Maintains an 8-bit hex count and presents it as two nibbles. Each nibble drives one hex-to-segment encoder instance (tens digit / ones digit).

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive cycles a synchronized input must differ from its stable value before the stable value flips (10 ms @ 25 MHz); minimum 2.
- REPEAT_DELAY_CYCLES, 12500000: cycles from the first step to the first auto-repeat step (0.5 s); minimum 2.
- REPEAT_RATE_CYCLES, 2500000: cycles between subsequent auto-repeat steps (0.1 s); minimum 2.

Ports:
- i_Clk  input  1  system clock (25 MHz)
- i_Rst_L  input  1  synchronous active-low reset
- i_Up_Button  input  1  raw pushbutton, active-high, asynchronous to i_Clk
- i_Down_Button  input  1  raw pushbutton, active-high, asynchronous
- i_Clear_Button  input  1  raw pushbutton, active-high, asynchronous
- o_Upper_Nibble  output  4  count[7:4]
- o_Lower_Nibble  output  4  count[3:0]
- o_Step  output  1  one-cycle pulse on every count change from Up/Down (not Clear)

Behaviour:

Reset (i_Rst_L low at a rising edge):
- All synchronizers, debounce counters and stable values go to 0.
- FSM goes to IDLE; count = 8'h00; o_Step = 0.
- Reset mid-hold aborts any repeat. A button still held after reset re-debounces from stable=0 and produces one fresh step.

Synchronizer:
- Two flops per button; synchronized value s lags raw by 2 edges.

Debounce, per button:
- cnt clears whenever s == stable.
- While s != stable, cnt increments.
- When s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s, cnt <= 0.
- Net effect: stable flips after DEBOUNCE_CYCLES consecutive differing cycles.
- Glitches shorter than DEBOUNCE_CYCLES never reach stable.

Direction:
- UP when Up stable=1 and Down stable=0; DOWN when the reverse.
- NONE when both are 0 or both are 1.

FSM (state, latched dir, repeat counter rc):
- IDLE: if dir != NONE, issue step(dir), latch dir, rc <= 0, go to DELAY.
- DELAY: if dir != latched, go to IDLE with no step. Else if rc == REPEAT_DELAY_CYCLES-1, issue step, rc <= 0, go to REPEAT. Else rc++.
- REPEAT: if dir != latched, go to IDLE. Else if rc == REPEAT_RATE_CYCLES-1, issue step, rc <= 0. Else rc++.
- Switching Up to Down directly passes through IDLE for 1 cycle, then steps DOWN on the next cycle.
- Pressing both buttons gives NONE, so no steps.

Step:
- count <= count ± 1, modulo 256: FF+1 = 00, 00-1 = FF.
- o_Step = 1 for exactly that cycle; count is visible on the same edge.

Clear:
- On the rising edge of Clear stable (0→1), count <= 8'h00 on that edge.
- Clear has priority over a step in the same cycle; o_Step stays 0 in that cycle.
- FSM state is unaffected, so repeating continues from 00.
- Holding Clear does not re-clear.

Latency:
- Raw Up rises and stays high: count changes at edge N+2+DEBOUNCE_CYCLES+1, where edge N is the first edge that samples it high.

Outputs:
- Registered; o_Upper_Nibble = count[7:4], o_Lower_Nibble = count[3:0].

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3):
1. Reset, then hold Up 6 cycles and release → exactly one o_Step pulse; nibbles 0/1; pulse at edge 7 after first sample.
2. Hold Up for 40 cycles → steps at t0, t0+10, t0+13, t0+16, …; count increments each step, o_Step count equals count value; release → no further steps.
3. Count at 8'h0F, press Up → 8'h10 (upper 1, lower 0). At 8'hFF, Up → 8'h00. At 8'h00, Down → 8'hFF.
4. Up glitches of 1, 2, 3 cycles separated by low gaps → no o_Step, count unchanged. Both buttons held together → no steps.
5. Hold Up in REPEAT, assert Clear so its stable rise coincides with a repeat step → count 00, o_Step 0 that cycle; next repeat gives 01.
6. Hold Up into REPEAT, pulse i_Rst_L low 1 cycle with Up still held → count 00 immediately; one step after 2+4+1 edges; next step 10 cycles later.
